// File: rtl/dac_pkg.sv
// Shared types and constants for the audio DAC sample path.
// Used by the CPU-side writer and the MMIO status decode.
package dac_pkg;

  localparam int SAMPLE_WIDTH = 12;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int STAT_FULL_BIT = 0;
  localparam int STAT_OVF_BIT  = 1;
  localparam int STAT_RUN_BIT  = 2;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO, head visible with no read latency.
// Push when full and pop when empty are ignored.
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Sample storage; contents are only meaningful under r_count.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dac_sample_writer.sv
// CPU-domain producer: buffers samples and paces them into the
// async FIFO at the programmed sample period.
module dac_sample_writer
  import dac_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int WIDTH        = SAMPLE_WIDTH,
  parameter int PERIOD_WIDTH = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    cpu_wr_en,
  input  logic [WIDTH-1:0]        cpu_wr_data,
  output logic                    cpu_full,
  output logic [$clog2(DEPTH):0]  cpu_count,
  input  logic                    status_clr,
  output logic                    overflow,
  output logic [CNT_WIDTH-1:0]    underrun_count,
  input  logic                    fifo_full,
  output logic                    w_en,
  output logic [WIDTH-1:0]        w_data
);

  state_t                  r_state;
  state_t                  w_state_n;
  logic [PERIOD_WIDTH-1:0] r_cnt;
  logic [PERIOD_WIDTH-1:0] w_cnt_n;
  logic [PERIOD_WIDTH-1:0] w_pm1;
  logic                    r_pending;
  logic                    w_pending_n;
  logic                    w_run;
  logic                    w_tick;
  logic                    w_emit;
  logic                    w_empty;
  logic [WIDTH-1:0]        w_head;
  logic                    w_ovf_set;
  logic                    w_und_set;
  logic                    r_ovf;
  logic [CNT_WIDTH-1:0]    r_und;
  logic                    r_wen;
  logic [WIDTH-1:0]        r_wdata;

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (cpu_wr_en),
    .i_data  (cpu_wr_data),
    .i_pop   (w_emit),
    .o_head  (w_head),
    .o_count (cpu_count),
    .o_full  (cpu_full),
    .o_empty (w_empty)
  );

  // Period 0 behaves as 1; >= lets a shrunk period tick at once.
  assign w_pm1     = (period == '0) ? '0 : period - PERIOD_WIDTH'(1);
  assign w_run     = enable && (r_state == RUN);
  assign w_tick    = w_run && (r_cnt >= w_pm1);
  assign w_emit    = w_run && r_pending && !w_empty && !fifo_full;
  assign w_ovf_set = cpu_wr_en && cpu_full;
  assign w_und_set = w_tick && r_pending && !w_emit;

  // State, period counter and owed-sample flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_pending <= w_pending_n;
    end
  end

  // Next state: at most one sample is ever owed.
  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_pending_n = r_pending;
    if (!enable) begin
      w_state_n   = IDLE;
      w_cnt_n     = '0;
      w_pending_n = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_n   = RUN;
          w_cnt_n     = '0;
          w_pending_n = 1'b0;
        end
        RUN: begin
          w_cnt_n = w_tick ? '0 : r_cnt + PERIOD_WIDTH'(1);
          if (w_tick)      w_pending_n = 1'b1;
          else if (w_emit) w_pending_n = 1'b0;
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  // Sticky overflow and saturating underrun; events beat clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_und <= '0;
    end else begin
      if (w_ovf_set)       r_ovf <= 1'b1;
      else if (status_clr) r_ovf <= 1'b0;
      if (w_und_set) begin
        if (status_clr)       r_und <= CNT_WIDTH'(1);
        else if (r_und != '1) r_und <= r_und + CNT_WIDTH'(1);
      end else if (status_clr) begin
        r_und <= '0;
      end
    end
  end

  // One-cycle write strobe into the async FIFO; data holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_wen <= w_emit;
      if (w_emit) r_wdata <= w_head;
    end
  end

  assign overflow       = r_ovf;
  assign underrun_count = r_und;
  assign w_en           = r_wen;
  assign w_data         = r_wdata;

endmodule
